// File: rtl/fetch_unit_pkg.sv
// Purpose : shared types and constants for the fetch stage (state enum, PCRegSelect codes).
// Latency : n/a (package only).
// Backpressure: n/a.
package definitions;

  // Default program-counter width; ROM depth is 2**PC_W.
  localparam int PC_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // PCRegSelect encodings shared by the save and jump paths.
  localparam logic [1:0] kPCNone = 2'b00;
  localparam logic [1:0] kPCReg1 = 2'b01;
  localparam logic [1:0] kPCReg2 = 2'b10;
  localparam logic [1:0] kPCReg3 = 2'b11;

endpackage

// File: rtl/fetch_unit_pc_save_regs.sv
// Purpose : bank of three saved-address registers (PCreg1..3) used as jump targets.
// Latency : write lands on the next rising edge; read port is combinational.
// Backpressure: none; one write per cycle is always accepted.
// Ports   : clk/rst (async active-high), clr (sync clear, wins over write),
//           we/wsel/wdata (write port, wsel=00 ignored), rsel/rdata (read port, rsel=00 reads 0).
module pc_save_regs
  import definitions::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            we,
  input  logic [1:0]      wsel,
  input  logic [PC_W-1:0] wdata,
  input  logic [1:0]      rsel,
  output logic [PC_W-1:0] rdata
);

  logic [PC_W-1:0] regs [1:3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= 3; i++) regs[i] <= '0;
    end else if (clr) begin
      for (int i = 1; i <= 3; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i <= 3; i++) begin
        if (we && (wsel == 2'(i))) regs[i] <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (rsel)
      kPCReg1: rdata = regs[1];
      kPCReg2: rdata = regs[2];
      kPCReg3: rdata = regs[3];
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Purpose : program counter + IDLE/RUN/HALT sequencer feeding the instruction ROM; handles
//           je/jne jumps to saved registers and spc saves. Optional macro FETCH_JUMP_COUNT_EN
//           enables a saturating 16-bit taken-jump counter (JumpCount tied to 0 otherwise).
// Latency : one cycle from decoded strobes to ProgCtr update; no delay slots.
// Backpressure: none; Start holds the program at address 0, Ack freezes it in HALT.
// Ports   : Clk, Reset (async active-high), Start, JumpEqual, JumpNotEqual, OffsetEn,
//           PCRegSelect[1:0], SaveEn, EqualFlag, Ack -> ProgCtr[PC_W-1:0], Done, JumpCount[15:0].
module fetch_unit
  import definitions::*;
#(
  parameter int PC_W       = PC_W_DEF,
  parameter int SPC_OFFSET = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            JumpEqual,
  input  logic            JumpNotEqual,
  input  logic            OffsetEn,
  input  logic [1:0]      PCRegSelect,
  input  logic            SaveEn,
  input  logic            EqualFlag,
  input  logic            Ack,
  output logic [PC_W-1:0] ProgCtr,
  output logic            Done,
  output logic [15:0]     JumpCount
);

  fetch_state_t    state, state_nxt;
  logic            taken;
  logic            jump;
  logic            save_we;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] jump_tgt;
  logic [PC_W-1:0] save_data;

  // ---------------- state register ----------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    if (Start) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     if (Ack) state_nxt = HALT;
        HALT:    state_nxt = HALT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---------------- output / datapath control ----------------
  // A jump only counts as taken with a real register selected. A taken jump
  // suppresses any save decoded in the same cycle, and Ack (the halt
  // instruction) freezes everything, so saves only ride along with increments.
  always_comb begin
    taken   = (JumpEqual & EqualFlag) | (JumpNotEqual & ~EqualFlag);
    jump    = 1'b0;
    save_we = 1'b0;
    pc_nxt  = ProgCtr;
    if (Start) begin
      pc_nxt = '0;
    end else begin
      case (state)
        IDLE: pc_nxt = '0;
        RUN: begin
          if (Ack) begin
            pc_nxt = ProgCtr;
          end else if (taken && (PCRegSelect != kPCNone)) begin
            jump   = 1'b1;
            pc_nxt = jump_tgt;
          end else begin
            save_we = SaveEn;
            pc_nxt  = ProgCtr + PC_W'(1);
          end
        end
        default: pc_nxt = ProgCtr;
      endcase
    end
  end

  // Saved value is relative to the address of the spc instruction itself.
  assign save_data = ProgCtr + (OffsetEn ? PC_W'(SPC_OFFSET) : PC_W'(0));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ProgCtr <= '0;
      Done    <= 1'b0;
    end else begin
      ProgCtr <= pc_nxt;
      Done    <= (state_nxt == HALT);
    end
  end

  // Read and write share the select; the read sees the pre-edge value, so a
  // jump through the register being written would use the old contents.
  pc_save_regs #(
    .PC_W (PC_W)
  ) u_save_regs (
    .clk   (Clk),
    .rst   (Reset),
    .clr   (Start),
    .we    (save_we),
    .wsel  (PCRegSelect),
    .wdata (save_data),
    .rsel  (PCRegSelect),
    .rdata (jump_tgt)
  );

`ifdef FETCH_JUMP_COUNT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      JumpCount <= '0;
    end else if (Start) begin
      JumpCount <= '0;
    end else if (jump && (JumpCount != 16'hFFFF)) begin
      JumpCount <= JumpCount + 16'd1;
    end
  end
`else
  assign JumpCount = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed table of vectors, hand sequences for wrap,
// save-with-offset at the top address and asynchronous reset, then random
// stimulus checked against a behavioural model of the fetch rules.
module tb_fetch_unit;

  localparam int PCW   = 10;
  localparam int DEPTH = 1 << PCW;
  localparam int OFF   = 2;
`ifdef FETCH_JUMP_COUNT_EN
  localparam bit JC_EN = 1'b1;
`else
  localparam bit JC_EN = 1'b0;
`endif

  logic           Clk = 1'b0;
  logic           Reset;
  logic           Start, JumpEqual, JumpNotEqual, OffsetEn, SaveEn, EqualFlag, Ack;
  logic [1:0]     PCRegSelect;
  logic [PCW-1:0] ProgCtr;
  logic           Done;
  logic [15:0]    JumpCount;

  int total = 0;
  int bad   = 0;

  // Behavioural model: mode 0=waiting at start, 1=running, 2=halted.
  int m_pc, m_jc, m_mode;
  int m_reg [4];
  bit m_done;

  fetch_unit #(.PC_W(PCW), .SPC_OFFSET(OFF)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .JumpEqual(JumpEqual),
    .JumpNotEqual(JumpNotEqual), .OffsetEn(OffsetEn), .PCRegSelect(PCRegSelect),
    .SaveEn(SaveEn), .EqualFlag(EqualFlag), .Ack(Ack), .ProgCtr(ProgCtr),
    .Done(Done), .JumpCount(JumpCount)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic st, je, jne, off;
    logic [1:0] sel;
    logic sv, eq, ack;
    int   pc;
    logic done;
    int   jc;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(logic st, logic je, logic jne, logic off, logic [1:0] sel,
                              logic sv, logic eq, logic ack, int pc, logic done, int jc);
    vec_t v;
    v.st = st; v.je = je; v.jne = jne; v.off = off; v.sel = sel;
    v.sv = sv; v.eq = eq; v.ack = ack; v.pc = pc; v.done = done; v.jc = jc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_pc = 0; m_jc = 0; m_mode = 0; m_done = 1'b0;
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
  endfunction

  function automatic void model_edge(input logic st, je, jne, off, input logic [1:0] sel,
                                     input logic sv, eq, ack);
    bit tk;
    if (st) begin
      m_pc = 0; m_jc = 0; m_mode = 0;
      for (int i = 0; i < 4; i++) m_reg[i] = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (ack) begin
        m_mode = 2;
      end else begin
        tk = (sel != 2'd0) && ((je && eq) || (jne && !eq));
        if (tk) begin
          m_pc = m_reg[sel];
          if (m_jc < 65535) m_jc++;
        end else begin
          if (sv && sel != 2'd0) m_reg[sel] = (m_pc + (off ? OFF : 0)) % DEPTH;
          m_pc = (m_pc + 1) % DEPTH;
        end
      end
    end
    m_done = (m_mode == 2);
  endfunction

  // One clock: drive inputs, take the edge, advance the model, compare 1 unit later.
  task automatic cyc(input logic st, je, jne, off, input logic [1:0] sel,
                     input logic sv, eq, ack);
    Start = st; JumpEqual = je; JumpNotEqual = jne; OffsetEn = off;
    PCRegSelect = sel; SaveEn = sv; EqualFlag = eq; Ack = ack;
    @(posedge Clk);
    model_edge(st, je, jne, off, sel, sv, eq, ack);
    #1;
    check("pc_vs_model", 32'(ProgCtr), 32'(m_pc));
    check("done_vs_model", 32'(Done), 32'(m_done));
    check("jc_vs_model", 32'(JumpCount), JC_EN ? 32'(m_jc) : 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 2'd0, 0, 0, 0);
  endtask

  initial begin
    Reset = 1'b1;
    Start = 0; JumpEqual = 0; JumpNotEqual = 0; OffsetEn = 0;
    PCRegSelect = 2'd0; SaveEn = 0; EqualFlag = 0; Ack = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check("reset_pc", 32'(ProgCtr), 32'd0);
    check("reset_done", 32'(Done), 32'd0);
    check("reset_jc", 32'(JumpCount), 32'd0);
    Reset = 1'b0;

    // ---------- directed table ----------
    //              st je jn of sel  sv eq ak   pc done jc
    tbl[0]  = mk(1, 0, 0, 0, 2'd0, 0, 0, 0,  0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 2'd0, 0, 0, 0,  0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 2'd0, 0, 0, 0,  0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 2'd0, 0, 0, 0,  1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 2'd0, 0, 0, 0,  2, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 2'd0, 0, 0, 0,  3, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 2'd0, 0, 0, 0,  4, 0, 0);
    tbl[7]  = mk(0, 1, 0, 0, 2'd0, 0, 1, 0,  5, 0, 0);  // je with sel=00: not taken
    tbl[8]  = mk(0, 0, 0, 1, 2'd2, 1, 0, 0,  6, 0, 0);  // spc at 5 -> PCreg2=7
    tbl[9]  = mk(0, 0, 0, 0, 2'd0, 0, 0, 0,  7, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 2'd0, 0, 0, 0,  8, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 2'd0, 0, 0, 0,  9, 0, 0);
    tbl[12] = mk(0, 0, 1, 0, 2'd2, 0, 0, 0,  7, 0, 1);  // jne taken -> 7
    tbl[13] = mk(0, 0, 0, 0, 2'd0, 0, 0, 0,  8, 0, 1);
    tbl[14] = mk(0, 0, 0, 0, 2'd0, 0, 0, 0,  9, 0, 1);
    tbl[15] = mk(0, 0, 1, 0, 2'd2, 0, 1, 0, 10, 0, 1);  // jne not taken
    tbl[16] = mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 11, 0, 1);
    tbl[17] = mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 12, 0, 1);
    tbl[18] = mk(0, 0, 0, 0, 2'd0, 0, 0, 1, 12, 1, 1);  // Ack at 12
    tbl[19] = mk(0, 1, 0, 1, 2'd2, 1, 1, 0, 12, 1, 1);  // strobes ignored in HALT
    tbl[20] = mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 12, 1, 1);
    tbl[21] = mk(1, 0, 0, 0, 2'd0, 0, 0, 0,  0, 0, 0);
    tbl[22] = mk(0, 0, 0, 0, 2'd0, 0, 0, 0,  0, 0, 0);
    tbl[23] = mk(0, 0, 0, 0, 2'd0, 0, 0, 0,  1, 0, 0);

    for (int i = 0; i < 24; i++) begin
      cyc(tbl[i].st, tbl[i].je, tbl[i].jne, tbl[i].off, tbl[i].sel,
          tbl[i].sv, tbl[i].eq, tbl[i].ack);
      check($sformatf("tbl%0d_pc", i), 32'(ProgCtr), 32'(tbl[i].pc));
      check($sformatf("tbl%0d_done", i), 32'(Done), 32'(tbl[i].done));
      check($sformatf("tbl%0d_jc", i), 32'(JumpCount), JC_EN ? 32'(tbl[i].jc) : 32'd0);
    end

    // ---------- wrap at the top address, save with offset wraps too ----------
    cyc(1, 0, 0, 0, 2'd0, 0, 0, 0);
    cyc(0, 0, 0, 0, 2'd0, 0, 0, 0);
    idle(DEPTH - 1);
    check("top_addr", 32'(ProgCtr), 32'(DEPTH - 1));
    cyc(0, 0, 0, 1, 2'd1, 1, 0, 0);                 // PCreg1 = 1023+2 -> 1
    check("wrap_to_zero", 32'(ProgCtr), 32'd0);
    idle(3);
    cyc(0, 1, 0, 0, 2'd1, 0, 1, 0);
    check("jump_to_wrapped_save", 32'(ProgCtr), 32'd1);

    // ---------- asynchronous reset mid-run ----------
    cyc(1, 0, 0, 0, 2'd0, 0, 0, 0);
    cyc(0, 0, 0, 0, 2'd0, 0, 0, 0);
    idle(20);
    cyc(0, 0, 0, 0, 2'd1, 1, 0, 0);                 // PCreg1 = 20
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 0, 2'd1, 0, 1, 0);
      check("loop_jump", 32'(ProgCtr), 32'd20);
      if (k < 2) cyc(0, 0, 0, 0, 2'd0, 0, 0, 0);
    end
    idle(10);
    check("pre_reset_pc", 32'(ProgCtr), 32'd30);
    check("pre_reset_jc", 32'(JumpCount), JC_EN ? 32'd3 : 32'd0);
    Reset = 1'b1;
    #1;
    check("async_reset_pc", 32'(ProgCtr), 32'd0);
    check("async_reset_jc", 32'(JumpCount), 32'd0);
    check("async_reset_done", 32'(Done), 32'd0);
    model_reset();
    @(posedge Clk);
    #1 Reset = 1'b0;
    cyc(0, 0, 0, 0, 2'd0, 0, 0, 0);
    cyc(0, 0, 0, 0, 2'd0, 0, 0, 0);
    cyc(0, 1, 0, 0, 2'd1, 0, 1, 0);                 // PCreg1 must read 0
    check("pcreg1_cleared", 32'(ProgCtr), 32'd0);

    // ---------- random stimulus against the model ----------
    cyc(1, 0, 0, 0, 2'd0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      logic st, je, jne, off, sv, eq, ack;
      logic [1:0] sel;
      st  = ($urandom_range(0, 63) == 0);
      ack = ($urandom_range(0, 39) == 0);
      je  = ($urandom_range(0, 5) == 0);
      jne = ($urandom_range(0, 5) == 0);
      sv  = ack ? 1'b0 : ($urandom_range(0, 4) == 0);
      off = 1'($urandom_range(0, 1));
      eq  = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      cyc(st, je, jne, off, sel, sv, eq, ack);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
